// File: rtl/rob_nway.sv
// N-way reorder buffer: in-order allocate, out-of-order complete, in-order retire,
// and selective squash of everything younger than a mispredicted branch.
module rob_nway #(
    parameter  int N         = 2,
    parameter  int DEPTH     = 32,
    parameter  int C         = 2,
    parameter  int PAYLOAD_W = 64,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int RC_W      = $clog2(N + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           alloc_valid,
    input  logic [N*PAYLOAD_W-1:0] alloc_payload,
    output logic [N*IDX_W-1:0]     alloc_idxs,
    output logic [CNT_W-1:0]       free_slots,
    input  logic [C-1:0]           cmp_valid,
    input  logic [C*IDX_W-1:0]     cmp_idx,
    input  logic [C-1:0]           cmp_exc,
    output logic [N*PAYLOAD_W-1:0] head_payload,
    output logic [N-1:0]           head_valids,
    output logic [N-1:0]           head_exc,
    input  logic [RC_W-1:0]        retire_count,
    input  logic                   mispredict,
    input  logic [IDX_W-1:0]       mispred_idx
);

    // Handshakes: there is no ready signal. An alloc group is taken whole when its
    // contiguous length fits in free_slots (and no mispredict), otherwise dropped whole;
    // retire takes min(retire_count, head_valids prefix length); completions to
    // invalid or just-squashed entries are silently dropped.

    logic [IDX_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     valid_q, cmpl_q, exc_q;
    logic [DEPTH-1:0]     valid_d, cmpl_d, exc_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    logic [IDX_W-1:0]     head_ptr [N];
    logic [IDX_W-1:0]     tail_ptr [N];

    logic [RC_W-1:0]      run_len, alloc_n, ready_cnt, retire_n;
    logic                 run_on, alloc_ok, prefix_ok;
    logic [CNT_W-1:0]     free_cnt, squash_n;
    logic [IDX_W-1:0]     br_off, off;
    logic                 retire_clr, squash_clr, hit, hit_exc;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_ptr[i] = head_q + IDX_W'(i);
            tail_ptr[i] = tail_q + IDX_W'(i);
        end
    end

    always_comb begin
        alloc_idxs = '0;
        for (int i = 0; i < N; i++) begin
            alloc_idxs[i*IDX_W +: IDX_W] = tail_ptr[i];
        end
    end

    assign free_cnt   = CNT_W'(DEPTH) - count_q;
    assign free_slots = free_cnt;

    // Only the low contiguous run of alloc_valid counts as a request.
    always_comb begin
        run_len = '0;
        run_on  = 1'b1;
        for (int i = 0; i < N; i++) begin
            run_on = run_on & alloc_valid[i];
            if (run_on) begin
                run_len = run_len + RC_W'(1);
            end
        end
    end

    assign alloc_ok = !mispredict && (CNT_W'(run_len) <= free_cnt);
    assign alloc_n  = alloc_ok ? run_len : '0;

    // An exceptional entry may be retired but ends the ready prefix.
    always_comb begin
        prefix_ok    = 1'b1;
        ready_cnt    = '0;
        head_valids  = '0;
        head_exc     = '0;
        head_payload = '0;
        for (int i = 0; i < N; i++) begin
            head_payload[i*PAYLOAD_W +: PAYLOAD_W] = payload_q[head_ptr[i]];
            head_exc[i]    = valid_q[head_ptr[i]] & exc_q[head_ptr[i]];
            head_valids[i] = prefix_ok & valid_q[head_ptr[i]] & cmpl_q[head_ptr[i]];
            prefix_ok      = head_valids[i] & ~exc_q[head_ptr[i]];
            if (head_valids[i]) begin
                ready_cnt = ready_cnt + RC_W'(1);
            end
        end
    end

    assign retire_n = (retire_count < ready_cnt) ? retire_count : ready_cnt;

    assign br_off   = mispred_idx - head_q;
    assign squash_n = mispredict ? (count_q - CNT_W'(1) - CNT_W'(br_off)) : '0;

    // Per-entry update order: completion, then allocation, then retire/squash clears.
    always_comb begin
        valid_d    = valid_q;
        cmpl_d     = cmpl_q;
        exc_d      = exc_q;
        off        = '0;
        retire_clr = 1'b0;
        squash_clr = 1'b0;
        hit        = 1'b0;
        hit_exc    = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            off        = IDX_W'(j) - head_q;
            retire_clr = CNT_W'(off) < CNT_W'(retire_n);
            squash_clr = mispredict && (off > br_off) && (CNT_W'(off) < count_q);
            hit        = 1'b0;
            hit_exc    = 1'b0;
            for (int p = 0; p < C; p++) begin
                if (cmp_valid[p] && (cmp_idx[p*IDX_W +: IDX_W] == IDX_W'(j))) begin
                    hit     = 1'b1;
                    hit_exc = hit_exc | cmp_exc[p];
                end
            end
            if (hit && valid_q[j] && !squash_clr) begin
                cmpl_d[j] = 1'b1;
                exc_d[j]  = exc_q[j] | hit_exc;
            end
            for (int i = 0; i < N; i++) begin
                if ((RC_W'(i) < alloc_n) && (tail_ptr[i] == IDX_W'(j))) begin
                    valid_d[j] = 1'b1;
                    cmpl_d[j]  = 1'b0;
                    exc_d[j]   = 1'b0;
                end
            end
            if (retire_clr || squash_clr) begin
                valid_d[j] = 1'b0;
                cmpl_d[j]  = 1'b0;
                exc_d[j]   = 1'b0;
            end
        end
    end

    assign count_d = count_q + CNT_W'(alloc_n) - CNT_W'(retire_n) - squash_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            cmpl_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_q + IDX_W'(retire_n);
            tail_q  <= mispredict ? (mispred_idx + IDX_W'(1)) : (tail_q + IDX_W'(alloc_n));
            count_q <= count_d;
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
            exc_q   <= exc_d;
        end
    end

    // Payload storage needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (RC_W'(i) < alloc_n) begin
                payload_q[tail_ptr[i]] <= alloc_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

endmodule
